// File: rtl/operand_scoreboard.sv
// ---------------------------------------------------------------------------
// operand_scoreboard
//   Tracks in-flight destination registers for the decode stage. Each of the
//   2 x 2**REG_W entries (GPR file, FPR file) holds a busy bit and a
//   countdown of cycles until its result can be forwarded. Decode is stalled
//   while a source it reads is busy with a non-zero countdown. A per-source
//   fwd_ok flag tells the forwarding selector that it can supply the value.
//
//   Handshake: an issue is a valid/ready transfer with iss_valid as valid and
//   ~stall as ready. The entry is written only on an edge where
//   iss_valid & ~stall. A stalled issue leaves no trace, and decode holds
//   iss_* stable until it is accepted.
//
//   Optional feature macro: SCOREBOARD_WAW_STALL_EN. When it is defined,
//   decode also stalls if the issue target is busy with a countdown longer
//   than the new latency, so a younger, faster producer cannot overtake an
//   older one.
//
// Ports
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   iss_valid/fp/rd/lat   issue of a register-writing instruction
//   src_valid/fp/idx      NSRC decode source queries (packed, source k at k)
//   wb_valid/fp/rd        writeback that releases an entry
//   stall                 decode must hold; the issue is not accepted
//   fwd_ok                source k is pending and forwardable now
//   busy_cnt              registered count of busy entries in both files
// ---------------------------------------------------------------------------
module operand_scoreboard #(
    parameter  int REG_W   = 5,
    parameter  int MAX_LAT = 7,
    parameter  int NSRC    = 3,
    localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic                    iss_fp,
    input  logic [REG_W-1:0]        iss_rd,
    input  logic [CNT_W-1:0]        iss_lat,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC-1:0]         src_fp,
    input  logic [NSRC*REG_W-1:0]   src_idx,
    input  logic                    wb_valid,
    input  logic                    wb_fp,
    input  logic [REG_W-1:0]        wb_rd,
    output logic                    stall,
    output logic [NSRC-1:0]         fwd_ok,
    output logic [REG_W+1:0]        busy_cnt
);

    localparam int NENT = 2 ** REG_W;
    localparam int BC_W = REG_W + 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LAT);

    logic [NENT-1:0]  busy [2];
    logic [CNT_W-1:0] cnt  [2][NENT];

    logic [CNT_W-1:0] lat_sat;
    logic             iss_gpr0;
    logic             raw_stall;
    logic             waw_hit;
    logic             iss_acc;
    logic             wb_hit;
    logic             same_entry;
    logic             cnt_inc;
    logic             cnt_dec;

    assign lat_sat  = (iss_lat > MAX_CNT) ? MAX_CNT : iss_lat;
    // GPR 0 is hardwired to zero: it never has a producer to wait for.
    assign iss_gpr0 = ~iss_fp & (iss_rd == '0);

    // Source queries. GPR 0 is masked explicitly even though it can never be busy.
    always_comb begin
        logic [REG_W-1:0] idx;
        logic             pend;
        raw_stall = 1'b0;
        fwd_ok    = '0;
        idx       = '0;
        pend      = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx  = src_idx[k*REG_W +: REG_W];
            pend = src_valid[k] & ~(~src_fp[k] & (idx == '0)) & busy[src_fp[k]][idx];
            if (pend && cnt[src_fp[k]][idx] != '0)
                raw_stall = 1'b1;
            fwd_ok[k] = pend & (cnt[src_fp[k]][idx] == '0);
        end
    end

`ifdef SCOREBOARD_WAW_STALL_EN
    assign waw_hit = iss_valid & ~iss_gpr0 & busy[iss_fp][iss_rd]
                   & (cnt[iss_fp][iss_rd] > lat_sat);
`else
    assign waw_hit = 1'b0;
`endif

    assign stall   = raw_stall | waw_hit;
    assign iss_acc = iss_valid & ~stall & ~iss_gpr0;

    // busy_cnt moves by at most one step each way per edge. A writeback to
    // the entry being issued in the same cycle is absorbed by the issue.
    assign wb_hit     = wb_valid & busy[wb_fp][wb_rd];
    assign same_entry = iss_acc & (iss_fp == wb_fp) & (iss_rd == wb_rd);
    assign cnt_inc    = iss_acc & ~busy[iss_fp][iss_rd];
    assign cnt_dec    = wb_hit & ~same_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < 2; f++) begin
                busy[f] <= '0;
                for (int e = 0; e < NENT; e++)
                    cnt[f][e] <= '0;
            end
            busy_cnt <= '0;
        end else begin
            for (int f = 0; f < 2; f++) begin
                for (int e = 0; e < NENT; e++) begin
                    if (iss_acc && iss_fp == 1'(f) && iss_rd == REG_W'(e)) begin
                        // The newest producer owns the entry, even over a same-edge writeback.
                        busy[f][e] <= 1'b1;
                        cnt[f][e]  <= lat_sat;
                    end else if (wb_valid && wb_fp == 1'(f) && wb_rd == REG_W'(e)) begin
                        busy[f][e] <= 1'b0;
                        cnt[f][e]  <= '0;
                    end else if (busy[f][e] && cnt[f][e] != '0) begin
                        cnt[f][e] <= cnt[f][e] - 1'b1;
                    end
                end
            end
            busy_cnt <= busy_cnt + BC_W'(cnt_inc) - BC_W'(cnt_dec);
        end
    end

endmodule

// File: tb/tb_operand_scoreboard.sv
module tb_operand_scoreboard;

  localparam int REG_W   = 5;
  localparam int MAX_LAT = 7;
  localparam int NSRC    = 3;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int NENT    = 2 ** REG_W;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  iss_valid;
  logic                  iss_fp;
  logic [REG_W-1:0]      iss_rd;
  logic [CNT_W-1:0]      iss_lat;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC-1:0]       src_fp;
  logic [NSRC*REG_W-1:0] src_idx;
  logic                  wb_valid;
  logic                  wb_fp;
  logic [REG_W-1:0]      wb_rd;
  logic                  stall;
  logic [NSRC-1:0]       fwd_ok;
  logic [REG_W+1:0]      busy_cnt;

  always #5 clk = ~clk;

  operand_scoreboard #(.REG_W(REG_W), .MAX_LAT(MAX_LAT), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_fp(iss_fp), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .src_valid(src_valid), .src_fp(src_fp), .src_idx(src_idx),
    .wb_valid(wb_valid), .wb_fp(wb_fp), .wb_rd(wb_rd),
    .stall(stall), .fwd_ok(fwd_ok), .busy_cnt(busy_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each busy register remembers the absolute edge number from which its
  // value is forwardable; the wait left is that edge minus the current edge.
  int tnow = 0;
  bit mbusy [2][NENT];
  int ready [2][NENT];

  function automatic int remaining(input int f, input int i);
    int r;
    r = ready[f][i] - tnow;
    return (r > 0) ? r : 0;
  endfunction

  function automatic int sat_lat(input int l);
    return (l > MAX_LAT) ? MAX_LAT : l;
  endfunction

  function automatic void model_out(output logic st, output logic [NSRC-1:0] fw);
    int f, i;
    st = 1'b0;
    fw = '0;
    for (int k = 0; k < NSRC; k++) begin
      f = int'(src_fp[k]);
      i = int'(src_idx[k*REG_W +: REG_W]);
      if (src_valid[k] && !(f == 0 && i == 0) && mbusy[f][i]) begin
        if (remaining(f, i) > 0) st = 1'b1;
        else fw[k] = 1'b1;
      end
    end
`ifdef SCOREBOARD_WAW_STALL_EN
    if (iss_valid && !(iss_fp == 1'b0 && iss_rd == '0) && mbusy[iss_fp][iss_rd]
        && remaining(int'(iss_fp), int'(iss_rd)) > sat_lat(int'(iss_lat)))
      st = 1'b1;
`endif
  endfunction

  function automatic int model_busy_count();
    int n = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NENT; i++)
        if (mbusy[f][i]) n++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic st;
    logic [NSRC-1:0] fw;
    if (rst) begin
      for (int f = 0; f < 2; f++)
        for (int i = 0; i < NENT; i++) begin
          mbusy[f][i] = 1'b0;
          ready[f][i] = 0;
        end
    end else begin
      model_out(st, fw);
      tnow++;
      if (wb_valid) mbusy[wb_fp][wb_rd] = 1'b0;
      if (iss_valid && !st && !(iss_fp == 1'b0 && iss_rd == '0)) begin
        mbusy[iss_fp][iss_rd] = 1'b1;
        ready[iss_fp][iss_rd] = tnow + sat_lat(int'(iss_lat));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic st;
    logic [NSRC-1:0] fw;
    model_out(st, fw);
    check("cyc_stall", int'(stall), int'(st));
    check("cyc_fwd_ok", int'(fwd_ok), int'(fw));
    check("cyc_busy_cnt", int'(busy_cnt), model_busy_count());
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iss_valid = 1'b0; iss_fp = 1'b0; iss_rd = '0; iss_lat = '0;
    src_valid = '0; src_fp = '0; src_idx = '0;
    wb_valid = 1'b0; wb_fp = 1'b0; wb_rd = '0;
  endtask

  task automatic issue(input logic fp, input int rd, input int lat);
    iss_valid = 1'b1; iss_fp = fp; iss_rd = REG_W'(rd); iss_lat = CNT_W'(lat);
  endtask

  task automatic query(input int k, input logic fp, input int idx);
    src_valid[k] = 1'b1;
    src_fp[k]    = fp;
    src_idx[k*REG_W +: REG_W] = REG_W'(idx);
  endtask

  task automatic wb(input logic fp, input int rd);
    wb_valid = 1'b1; wb_fp = fp; wb_rd = REG_W'(rd);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();

    // 1: reset with random inputs
    tick();
    iss_valid = 1'b1; iss_rd = REG_W'($urandom_range(1, 31)); iss_lat = CNT_W'($urandom_range(0, 7));
    src_valid = '1; src_idx = NSRC*REG_W'($urandom); wb_valid = 1'b1;
    #2;
    check("t1_rst_stall", int'(stall), 0);
    check("t1_rst_fwd", int'(fwd_ok), 0);
    check("t1_rst_busy", int'(busy_cnt), 0);
    tick();
    clear_inputs();
    rst = 1'b0;
    query(1, 1'b0, 5);
    #2 check("t1_query_fwd", int'(fwd_ok), 0);
    tick();

    // 2: RAW countdown, GPR5 lat 3
    do_reset();
    issue(1'b0, 5, 3);
    #2 check("t2_c0_stall", int'(stall), 0);
    tick();
    clear_inputs();
    query(1, 1'b0, 5);
    check("t2_busy", int'(busy_cnt), 1);
    for (int c = 1; c <= 3; c++) begin
      #2 check("t2_stall", int'(stall), 1);
      check("t2_fwd_low", int'(fwd_ok), 0);
      tick();
    end
    for (int c = 4; c <= 6; c++) begin
      if (c == 6) wb(1'b0, 5);
      #2 check("t2_nostall", int'(stall), 0);
      check("t2_fwd", int'(fwd_ok), 3'b010);
      tick();
    end
    wb_valid = 1'b0;
    #2 check("t2_fwd_after_wb", int'(fwd_ok), 0);
    check("t2_busy_after_wb", int'(busy_cnt), 0);

    // 3: GPR0 and file separation
    do_reset();
    issue(1'b0, 0, 5);
    tick();
    check("t3_gpr0_busy", int'(busy_cnt), 0);
    issue(1'b1, 5, 2);
    tick();
    clear_inputs();
    query(0, 1'b0, 5);
    #1 check("t3_gpr5_stall", int'(stall), 0);
    query(0, 1'b1, 5);
    #1 check("t3_fpr5_stall1", int'(stall), 1);
    tick();
    #2 check("t3_fpr5_stall2", int'(stall), 1);
    tick();
    #2 check("t3_fpr5_free", int'(stall), 0);
    check("t3_fpr5_fwd", int'(fwd_ok), 3'b001);
    tick();

    // 4: same-edge issue and writeback, then writeback of an idle entry
    do_reset();
    issue(1'b0, 7, 0);
    tick();
    issue(1'b0, 7, 2);
    wb(1'b0, 7);
    tick();
    clear_inputs();
    check("t4_busy", int'(busy_cnt), 1);
    query(2, 1'b0, 7);
    #2 check("t4_stall1", int'(stall), 1);
    tick();
    #2 check("t4_stall2", int'(stall), 1);
    tick();
    #2 check("t4_fwd", int'(fwd_ok), 3'b100);
    clear_inputs();
    wb(1'b0, 9);
    tick();
    clear_inputs();
    check("t4_wb_idle_busy", int'(busy_cnt), 1);

    // 5: issue held off by a stall
    do_reset();
    issue(1'b0, 8, 3);
    tick();
    clear_inputs();
    query(0, 1'b0, 8);
    issue(1'b0, 3, 0);
    for (int c = 1; c <= 3; c++) begin
      #2 check("t5_stall", int'(stall), 1);
      tick();
      check("t5_not_taken", int'(busy_cnt), 1);
    end
    #2 check("t5_stall_drop", int'(stall), 0);
    tick();
    clear_inputs();
    check("t5_taken", int'(busy_cnt), 2);

    // 6: re-issue with a shorter latency
    do_reset();
    issue(1'b0, 4, 5);
    tick();
    issue(1'b0, 4, 1);
`ifdef SCOREBOARD_WAW_STALL_EN
    for (int c = 1; c <= 4; c++) begin
      #2 check("t6_waw_stall", int'(stall), 1);
      tick();
    end
`endif
    #2 check("t6_accept", int'(stall), 0);
    tick();
    clear_inputs();
    query(0, 1'b0, 4);
    #2 check("t6_short_stall", int'(stall), 1);
    tick();
    #2 check("t6_fwd", int'(fwd_ok), 3'b001);
    check("t6_busy", int'(busy_cnt), 1);
    tick();

    // asynchronous reset in the middle of a countdown
    do_reset();
    issue(1'b0, 6, 4);
    tick();
    clear_inputs();
    query(0, 1'b0, 6);
    #1 check("ar_stall_before", int'(stall), 1);
    rst = 1'b1;
    #1 check("ar_stall_drop", int'(stall), 0);
    check("ar_busy_clear", int'(busy_cnt), 0);
    tick();
    rst = 1'b0;
    clear_inputs();
    wb(1'b0, 6);
    tick();
    clear_inputs();
    check("ar_wb_noop", int'(busy_cnt), 0);

    // random traffic on a small register window so entries collide often
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_fp    = 1'($urandom_range(0, 1));
      iss_rd    = REG_W'($urandom_range(0, 7));
      iss_lat   = CNT_W'($urandom_range(0, 7));
      for (int k = 0; k < NSRC; k++) begin
        src_valid[k] = ($urandom_range(0, 2) != 0);
        src_fp[k]    = 1'($urandom_range(0, 1));
        src_idx[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
      end
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_fp    = 1'($urandom_range(0, 1));
      wb_rd    = REG_W'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
